inst_rom_arbiter: RTL and testbench

Shares the single combinational instruction ROM between the instruction-fetch stage and the memory-stage data side, which reads constants and literal pools from ROM space. The arbiter grants one requester per cycle, drives the ROM enable and address, and registers the ROM word into a one-cycle-latency response. Data side has priority, bounded by a fetch-starvation limit. A fetch flush discards in-flight fetch responses after branches.

---
 rtl/inst_rom_arbiter_pkg.sv | 22 ++
 rtl/inst_rom_arbiter_starve_ctr.sv | 46 ++++
 rtl/inst_rom_arbiter.sv | 109 ++++++++++
 tb/tb_inst_rom_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: widths, ROM word-index range
// and the response-owner encoding.
package inst_rom_arbiter_pkg;

    localparam int InstAddrWidth = 32;
    localparam int InstWidth     = 32;

    // ROM word index occupies byte-address bits [RomIdxHi:RomIdxLo]
    localparam int RomIdxHi = 18;
    localparam int RomIdxLo = 2;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DS   = 2'd2
    } rsp_owner_e;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; flags when fetch must win.
module rom_starve_ctr
    import inst_rom_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic if_flush,
    output logic starve_hit
);

    localparam int CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] LimitVal = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] cnt_r;
    logic [CntW-1:0] cnt_s;

    // Next count: grow while fetch waits unserved, otherwise restart from zero
    always_comb begin
        cnt_s = cnt_r;
        if (if_req && !if_gnt && !if_flush) begin
            if (cnt_r == LimitVal) begin
                cnt_s = cnt_r;
            end else begin
                cnt_s = cnt_r + CntW'(1);
            end
        end else begin
            cnt_s = {CntW{1'b0}};
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CntW{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign starve_hit = (cnt_r == LimitVal);

endmodule

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the shared combinational instruction ROM between fetch and the data
// side, returning the ROM word through a one-cycle registered response.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W       = InstAddrWidth,
    parameter int DATA_W       = InstWidth,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ds_req,
    input  logic [ADDR_W-1:0] ds_addr,
    output logic              ds_gnt,
    output logic              ds_rvalid,
    output logic [DATA_W-1:0] ds_rdata,
    output logic              ds_err,
    output logic              rom_inst_en,
    output logic [ADDR_W-1:0] rom_inst_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    logic        starve_hit_s;
    logic        if_gnt_s;
    logic        ds_gnt_s;
    logic        ds_ok_s;
    rsp_owner_e  owner_s;
    logic        err_s;
    logic [DATA_W-1:0] data_s;

    rsp_owner_e        rsp_owner_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_err_r;

    rom_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_gnt     (if_gnt_s),
        .if_flush   (if_flush),
        .starve_hit (starve_hit_s)
    );

    // Grant selection and ROM address mux; a misaligned data grant uses the slot without reading
    always_comb begin
        if_gnt_s      = if_req && !if_flush && (!ds_req || starve_hit_s);
        ds_gnt_s      = ds_req && !if_gnt_s;
        ds_ok_s       = word_aligned(ds_addr[1:0]);
        rom_inst_en   = 1'b0;
        rom_inst_addr = {ADDR_W{1'b0}};
        owner_s       = RSP_NONE;
        err_s         = 1'b0;
        if (if_gnt_s) begin
            rom_inst_en   = 1'b1;
            rom_inst_addr = if_addr;
            owner_s       = RSP_IF;
        end else if (ds_gnt_s) begin
            owner_s = RSP_DS;
            if (ds_ok_s) begin
                rom_inst_en   = 1'b1;
                rom_inst_addr = ds_addr;
            end else begin
                err_s = 1'b1;
            end
        end else begin
            owner_s = RSP_NONE;
        end
    end

    // ROM word captured only for a real read; kept apart from the mux to avoid a false loop
    always_comb begin
        data_s = {DATA_W{1'b0}};
        if (rom_inst_en) begin
            data_s = rom_inst;
        end else begin
            data_s = {DATA_W{1'b0}};
        end
    end

    // Response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner_r <= RSP_NONE;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            rsp_owner_r <= owner_s;
            rsp_data_r  <= data_s;
            rsp_err_r   <= err_s;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign ds_gnt    = ds_gnt_s;
    assign if_rvalid = (rsp_owner_r == RSP_IF) && !if_flush;
    assign ds_rvalid = (rsp_owner_r == RSP_DS);
    assign if_rdata  = rsp_data_r;
    assign ds_rdata  = rsp_data_r;
    assign ds_err    = ds_rvalid && rsp_err_r;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboard bench for inst_rom_arbiter: directed scenarios plus random traffic
// against a behavioural arbitration model and a simple ROM image.
module tb_inst_rom_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, ds_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = 32'h0, ds_addr = 32'h0;
    logic        if_gnt, if_rvalid, ds_gnt, ds_rvalid, ds_err, rom_inst_en;
    logic [31:0] if_rdata, ds_rdata, rom_inst_addr, rom_inst;

    typedef struct {
        int          owner;   // 1 = fetch, 2 = data side
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   sc = 0;
    logic g_if, g_ds;

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ds_req(ds_req), .ds_addr(ds_addr), .ds_gnt(ds_gnt),
        .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata), .ds_err(ds_err),
        .rom_inst_en(rom_inst_en), .rom_inst_addr(rom_inst_addr), .rom_inst(rom_inst)
    );

    function automatic logic [31:0] rom_word(input logic [16:0] idx);
        if (idx == 17'd4) return 32'h2402_0001;
        return {idx[15:0], ~idx[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign rom_inst = rom_inst_en ? rom_word(rom_inst_addr[18:2]) : 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts grants and ROM drive, queues the response
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic fl);
        exp_t e;
        logic aligned;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; ds_req = dr; ds_addr = da; if_flush = fl;
        @(negedge clk);
        g_if = ir && !fl && (!dr || sc >= LIMIT);
        g_ds = dr && !g_if;
        aligned = (da % 4 == 0);
        chk("if_gnt", {31'h0, if_gnt}, {31'h0, g_if});
        chk("ds_gnt", {31'h0, ds_gnt}, {31'h0, g_ds});
        chk("rom_en", {31'h0, rom_inst_en}, {31'h0, g_if || (g_ds && aligned)});
        if (g_if) chk("rom_addr", rom_inst_addr, ia);
        else if (g_ds && aligned) chk("rom_addr", rom_inst_addr, da);
        else if (!g_ds) chk("rom_addr_idle", rom_inst_addr, 32'h0);
        if (g_if) begin
            e.owner = 1; e.data = rom_word(ia[18:2]); e.err = 1'b0; e.due = cyc + 1;
            sb.push_back(e);
        end else if (g_ds) begin
            e.owner = 2; e.due = cyc + 1;
            e.data = aligned ? rom_word(da[18:2]) : 32'h0;
            e.err  = !aligned;
            sb.push_back(e);
        end
        if (ir && !g_if && !fl) sc = (sc < LIMIT) ? sc + 1 : LIMIT;
        else sc = 0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_if_gnt"},    {31'h0, if_gnt}, 32'h0);
        chk({tag, "_ds_gnt"},    {31'h0, ds_gnt}, 32'h0);
        chk({tag, "_if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
        chk({tag, "_ds_rvalid"}, {31'h0, ds_rvalid}, 32'h0);
        chk({tag, "_ds_err"},    {31'h0, ds_err}, 32'h0);
        chk({tag, "_if_rdata"},  if_rdata, 32'h0);
        chk({tag, "_ds_rdata"},  ds_rdata, 32'h0);
        chk({tag, "_rom_en"},    {31'h0, rom_inst_en}, 32'h0);
        chk({tag, "_rom_addr"},  rom_inst_addr, 32'h0);
    endtask

    // Monitor: matches each presented response against the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                chk("rsp_missing_due", sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                if (sb[0].owner == 1 && if_flush) begin
                    chk("if_rvalid_flushed", {31'h0, if_rvalid}, 32'h0);
                    chk("ds_rvalid_flushed", {31'h0, ds_rvalid}, 32'h0);
                end else if (sb[0].owner == 1) begin
                    chk("if_rvalid", {31'h0, if_rvalid}, 32'h1);
                    chk("ds_rvalid_on_if", {31'h0, ds_rvalid}, 32'h0);
                    chk("if_rdata", if_rdata, sb[0].data);
                end else begin
                    chk("ds_rvalid", {31'h0, ds_rvalid}, 32'h1);
                    chk("if_rvalid_on_ds", {31'h0, if_rvalid}, 32'h0);
                    chk("ds_rdata", ds_rdata, sb[0].data);
                    chk("ds_err", {31'h0, ds_err}, {31'h0, sb[0].err});
                end
                void'(sb.pop_front());
            end else if (if_rvalid || ds_rvalid) begin
                chk("unexpected_rvalid", {30'h0, if_rvalid, ds_rvalid}, 32'h0);
            end
        end
    end

    initial begin
        logic        if_pend, ds_pend, fl;
        logic [31:0] ia, da;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch of ROM[4]
        step(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
        chk("t1_if_gnt", {31'h0, if_gnt}, 32'h1);
        chk("t1_rom_addr", rom_inst_addr, 32'h0000_0010);
        idle();
        chk("t1_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("t1_if_rdata", if_rdata, 32'h2402_0001);

        // Both requesting: data side wins until fetch has starved LIMIT cycles
        for (int c = 0; c < 6; c++) begin
            step(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 1'b0);
            chk("starve_ds_gnt", {31'h0, ds_gnt}, {31'h0, c != 4});
        end
        idle();

        // Misaligned data access
        step(1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
        chk("mis_ds_gnt", {31'h0, ds_gnt}, 32'h1);
        chk("mis_rom_en", {31'h0, rom_inst_en}, 32'h0);
        idle();
        chk("mis_ds_rvalid", {31'h0, ds_rvalid}, 32'h1);
        chk("mis_ds_err", {31'h0, ds_err}, 32'h1);
        chk("mis_ds_rdata", ds_rdata, 32'h0);

        // Flush right after a fetch grant
        step(1'b1, 32'h0000_0030, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0034, 1'b0, 32'h0, 1'b1);
        chk("flush_if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("flush_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        idle();

        // Data then fetch back-to-back
        step(1'b0, 32'h0, 1'b1, 32'h0000_0050, 1'b0);
        step(1'b1, 32'h0000_0060, 1'b0, 32'h0, 1'b0);
        chk("b2b_ds_rvalid", {31'h0, ds_rvalid}, 32'h1);
        chk("b2b_ds_rdata", ds_rdata, rom_word(17'h14));
        idle();
        chk("b2b_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("b2b_if_rdata", if_rdata, rom_word(17'h18));

        // Reset in the cycle after a grant discards the response
        step(1'b1, 32'h0000_0070, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0; if_req = 1'b0; ds_req = 1'b0; if_flush = 1'b0;
        if_addr = 32'h0; ds_addr = 32'h0;
        sb.delete();
        sc = 0;
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        chk("post_rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        idle();

        // Random traffic; requests held until granted, flush redirects fetch
        if_pend = 1'b0; ds_pend = 1'b0; ia = 32'h0; da = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!if_pend && ($urandom % 3 != 0)) begin
                if_pend = 1'b1;
                ia = $urandom & 32'hffff_fffc;
            end
            if (!ds_pend && ($urandom % ((n < 1500) ? 4 : 2) == 0)) begin
                ds_pend = 1'b1;
                da = $urandom;
                if ($urandom % 4 != 0) da[1:0] = 2'b00;
            end
            fl = ($urandom % 10 == 0);
            step(if_pend, ia, ds_pend, da, fl);
            if (g_if || fl) if_pend = 1'b0;
            if (g_ds) ds_pend = 1'b0;
        end
        repeat (3) idle();
        chk("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
